// File: rtl/alu.sv
// alu: single-cycle registered 8-bit arithmetic/logic unit.
// Two unsigned 8-bit operands and a 3-bit operation select are sampled on
// every rising clock edge; the 16-bit result is held in an output register.
// The result width holds a full 8x8 product and sign-extended differences.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  Ain,
  input  logic [7:0]  Bin,
  input  logic [2:0]  mode,
  output logic [15:0] result
);

  // Operation encoding; all eight values are defined operations.
  typedef enum logic [2:0] {
    MODE_ADD = 3'd0,
    MODE_SUB = 3'd1,
    MODE_MUL = 3'd2,
    MODE_AND = 3'd3,
    MODE_OR  = 3'd4,
    MODE_XOR = 3'd5,
    MODE_SHL = 3'd6,
    MODE_CAT = 3'd7
  } alu_mode_e;

  alu_mode_e   w_mode;
  logic [15:0] w_a_ext;
  logic [15:0] w_b_ext;
  logic [2:0]  w_shamt;
  logic [15:0] w_next_result;
  logic [15:0] r_result;

  // Operands are zero-extended so every arithmetic op is done at 16 bits:
  // ADD carries into bit 8, SUB wraps to a sign-extended two's complement
  // value, and MUL keeps the full product.
  assign w_mode  = alu_mode_e'(mode);
  assign w_a_ext = {8'h00, Ain};
  assign w_b_ext = {8'h00, Bin};
  // Only the low three bits of Bin select the shift distance (0-7).
  assign w_shamt = Bin[2:0];

  // Next-result selection: a pure function of the current inputs.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block free of
    // inferred latches even if a branch is later edited to skip the output.
    w_next_result = 16'h0000;
    case (w_mode)
      MODE_ADD: w_next_result = w_a_ext + w_b_ext;
      MODE_SUB: w_next_result = w_a_ext - w_b_ext;
      MODE_MUL: w_next_result = w_a_ext * w_b_ext;
      MODE_AND: w_next_result = w_a_ext & w_b_ext;
      MODE_OR:  w_next_result = w_a_ext | w_b_ext;
      MODE_XOR: w_next_result = w_a_ext ^ w_b_ext;
      MODE_SHL: w_next_result = w_a_ext << w_shamt;
      MODE_CAT: w_next_result = {Ain, Bin};
      default:  w_next_result = 16'h0000;
    endcase
  end

  // Result register: synchronous reset wins over the in-flight operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values
    // regardless of the order in which always blocks are evaluated.
    if (rst) begin
      r_result <= 16'h0000;
    end else begin
      r_result <= w_next_result;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed vectors from the operation
// table plus randomized back-to-back traffic with sporadic resets, all checked
// against an arithmetic reference model one edge after the inputs are applied.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [7:0]  Ain;
  logic [7:0]  Bin;
  logic [2:0]  mode;
  logic [15:0] result;

  int n_vectors;
  int n_miscompares;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .Ain    (Ain),
    .Bin    (Bin),
    .mode   (mode),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, reduced modulo 2^16.
  function automatic logic [15:0] ref_model(input int a, input int b, input int m);
    int r;
    r = 0;
    case (m)
      0: r = a + b;
      1: r = a - b;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a * (2 ** (b % 8));
      7: r = a * 256 + b;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: result=0x%04h expected=0x%04h", tag, got, exp);
    end
  endtask

  // Apply one set of inputs, clock once, and compare against exp.
  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] m, input logic [15:0] exp, input string tag);
    rst  = r;
    Ain  = a;
    Bin  = b;
    mode = m;
    @(posedge clk);
    #1;
    check(tag, result, exp);
  endtask

  // Same as step, with the expectation taken from the reference model.
  task automatic step_model(input logic r, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] m, input string tag);
    logic [15:0] exp;
    exp = r ? 16'h0000 : ref_model(int'(a), int'(b), int'(m));
    step(r, a, b, m, exp, tag);
  endtask

  logic [15:0] mode_sweep_exp [8];
  logic [15:0] held;

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst  = 1'b1;
    Ain  = 8'h33;
    Bin  = 8'h44;
    mode = 3'd7;

    // Reset for two edges, then release.
    step(1'b1, 8'h33, 8'h44, 3'd7, 16'h0000, "reset_edge0");
    step(1'b1, 8'h33, 8'h44, 3'd7, 16'h0000, "reset_edge1");
    step(1'b0, 8'h33, 8'h44, 3'd7, 16'h3344, "post_reset_cat");

    // Mode sweep with fixed operands.
    mode_sweep_exp = '{16'h0077, 16'hFFEF, 16'h0D8C, 16'h0000,
                       16'h0077, 16'h0077, 16'h0330, 16'h3344};
    for (int m = 0; m < 8; m++) begin
      step(1'b0, 8'h33, 8'h44, 3'(m), mode_sweep_exp[m], $sformatf("sweep_mode%0d", m));
    end

    // Extremes and boundary cases.
    step(1'b0, 8'hFF, 8'hFF, 3'd0, 16'h01FE, "ff_add");
    step(1'b0, 8'hFF, 8'hFF, 3'd2, 16'hFE01, "ff_mul");
    step(1'b0, 8'hFF, 8'hFF, 3'd1, 16'h0000, "ff_sub");
    step(1'b0, 8'hFF, 8'hFF, 3'd5, 16'h0000, "ff_xor");
    step(1'b0, 8'h00, 8'h01, 3'd1, 16'hFFFF, "sub_neg1");
    step(1'b0, 8'h80, 8'hFF, 3'd6, 16'h4000, "shl_by7");
    step(1'b0, 8'h01, 8'hF8, 3'd6, 16'h0001, "shl_hi_ignored");

    // Inputs changing between edges must not disturb the registered result.
    step(1'b0, 8'h12, 8'h34, 3'd2, 16'h03A8, "stab_setup");
    held = 16'h03A8;
    Ain  = 8'hAB;
    Bin  = 8'hCD;
    mode = 3'd7;
    #2;
    check("stab_mid_cycle", result, held);
    Ain  = 8'h01;
    mode = 3'd0;
    #1;
    check("stab_mid_cycle2", result, held);
    @(posedge clk);
    #1;
    check("stab_next_edge", result, 16'h00CE);

    // Back-to-back sequence with a single reset cycle in the middle.
    step_model(1'b0, 8'h5A, 8'h0F, 3'd4, "b2b_0");
    step_model(1'b0, 8'h9C, 8'h27, 3'd1, "b2b_1");
    step(1'b1, 8'hC3, 8'h3C, 3'd2, 16'h0000, "b2b_reset");
    step_model(1'b0, 8'hC3, 8'h3C, 3'd2, "b2b_resume");
    step_model(1'b0, 8'h07, 8'h0B, 3'd6, "b2b_after");

    // Randomized back-to-back traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] m;
      r = ($urandom_range(0, 15) == 0);
      a = 8'($urandom);
      b = 8'($urandom);
      m = 3'($urandom);
      step_model(r, a, b, m, $sformatf("rand%0d_m%0d_a%02h_b%02h_r%0d", i, m, a, b, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Single-cycle registered 8-bit arithmetic/logic unit. It takes two unsigned 8-bit operands and a 3-bit operation select, and produces a 16-bit result. The result is wide enough to hold a full product and sign-extended differences. It sits as a leaf datapath block: operands and mode are sampled on each rising clock edge, and the result is held in an output register.

## Interface
- No parameters; widths are fixed (8-bit operands, 16-bit result).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Ain  input  8  operand A, unsigned.
- Bin  input  8  operand B, unsigned.
- mode  input  3  operation select.
- result  output  16  registered operation result.

The design uses one clock. Reset is synchronous and active-high.

## Operation
- Next result is a pure function of (Ain, Bin, mode), computed combinationally and captured into the result register.
- All arithmetic is 16-bit; operands are zero-extended to 16 bits before use unless stated otherwise.
- mode 0, ADD: {8'h00, Ain} + {8'h00, Bin}.
  - Carry lands in bit 8; bits 15:9 = 0; maximum 0x01FE.
- mode 1, SUB: Ain − Bin, as 16-bit two's complement.
  - A negative difference is sign-extended, e.g. 0x33 − 0x44 = 0xFFEF.
  - Equal operands give 0x0000.
- mode 2, MUL: unsigned Ain × Bin, full 16-bit product.
  - Maximum 0xFF × 0xFF = 0xFE01.
- mode 3, AND: {8'h00, Ain & Bin}.
- mode 4, OR: {8'h00, Ain | Bin}.
- mode 5, XOR: {8'h00, Ain ^ Bin}.
- mode 6, SHL: {8'h00, Ain} logically shifted left by Bin[2:0].
  - Shift range 0–7; zero fill.
  - Bin[7:3] are ignored.
- mode 7, CAT: {Ain, Bin}, with Ain in bits 15:8 and Bin in bits 7:0.
- Every mode value is defined; there is no illegal or undefined mode.
- No status flags or other outputs.

## Timing
- Reset: when rst = 1 at a rising clk edge, result becomes 0x0000 on that edge.
  - rst takes priority over the inputs.
  - result holds 0x0000 until the first edge with rst = 0.
- Latency: inputs present before rising edge N appear on result after edge N. That is one cycle, with no bubbles.
- Throughput: one operation per cycle. mode and operands may change every cycle independently.
- result changes only on rising clk edges; it never follows input changes combinationally.
- Reset asserted mid-stream discards the in-flight operation; result = 0x0000 after that edge.
- Operation resumes on the first non-reset edge, using the inputs present at that edge.
- No handshake: the block always accepts its inputs and always presents a result.

## Test plan
- Reset: assert rst for 2 cycles with Ain = 0x33, Bin = 0x44, mode = 7 -> result = 0x0000 after each reset edge. After deasserting, next edge -> 0x3344.
- Mode sweep with Ain = 0x33, Bin = 0x44, one mode per cycle, checking each result one edge after it is applied:
  - mode 0 -> 0x0077
  - mode 1 -> 0xFFEF
  - mode 2 -> 0x0D8C
  - mode 3 -> 0x0000
  - mode 4 -> 0x0077
  - mode 5 -> 0x0077
  - mode 6 -> 0x0330
  - mode 7 -> 0x3344
- Extremes with Ain = Bin = 0xFF:
  - ADD -> 0x01FE
  - MUL -> 0xFE01
  - SUB -> 0x0000
  - XOR -> 0x0000
- Ain = 0x00, Bin = 0x01 SUB -> 0xFFFF. Ain = 0x80, Bin = 0xFF SHL -> 0x4000 (shift of 7).
- Latency and mid-stream reset:
  - Change inputs between edges -> result stays stable until the next edge.
  - Assert rst for one cycle during a back-to-back sequence -> exactly that cycle's result is 0x0000, and the following results are correct.
